// File: rtl/vthernet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vthernet_pkg
//  Description : Shared receive-path types and default slot geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package vthernet_pkg;

    localparam int DEF_SLOT_NUM   = 4;
    localparam int DEF_SLOT_BYTES = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage : vthernet_pkg
`default_nettype wire

// File: rtl/rx_slot_ring.sv
`default_nettype none
// ============================================================================
//  Module      : rx_slot_ring
//  Description : Slot ring bookkeeping: write/read slot pointers, committed
//                slot count, per-slot frame lengths and registered head status.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_slot_ring
    import vthernet_pkg::*;
#(
    parameter  int SLOT_NUM   = DEF_SLOT_NUM,
    parameter  int SLOT_BYTES = DEF_SLOT_BYTES,
    localparam int SW         = $clog2(SLOT_NUM),
    localparam int BW         = $clog2(SLOT_BYTES),
    localparam int CW         = SW + 1,
    localparam int AW         = SW + BW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          commit,
    input  logic [BW:0]   commit_len,
    input  logic          release_req,
    output logic [SW-1:0] wr_slot,
    output logic          full,
    output logic          rx_avail,
    output logic [AW-1:0] head_base,
    output logic [BW:0]   head_len,
    output logic [SW:0]   slot_cnt
);

    logic [SW-1:0] r_wr_slot;
    logic [SW-1:0] r_rd_slot;
    logic [SW-1:0] w_rd_next;
    logic [CW-1:0] r_slot_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [BW:0]   r_len [SLOT_NUM];
    logic          r_avail;
    logic [BW:0]   r_head_len;
    logic          w_release;

    assign w_release = release_req && (r_slot_cnt != '0);
    assign w_rd_next = w_release ? r_rd_slot + SW'(1) : r_rd_slot;

    always_comb begin
        w_cnt_next = r_slot_cnt;
        if (commit && !w_release) begin
            w_cnt_next = r_slot_cnt + CW'(1);
        end else if (!commit && w_release) begin
            w_cnt_next = r_slot_cnt - CW'(1);
        end
    end

    // Status is built from next-state values so it lands on the same edge as
    // the pointer update. The bypass covers a commit into a ring whose head
    // is the slot being written (empty ring, or release+commit at count 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_slot  <= '0;
            r_rd_slot  <= '0;
            r_slot_cnt <= '0;
            r_avail    <= 1'b0;
            r_head_len <= '0;
        end else begin
            if (commit) begin
                r_wr_slot <= r_wr_slot + SW'(1);
            end
            r_rd_slot  <= w_rd_next;
            r_slot_cnt <= w_cnt_next;
            r_avail    <= (w_cnt_next != '0);
            if (w_cnt_next == '0) begin
                r_head_len <= '0;
            end else if (commit && (r_wr_slot == w_rd_next)) begin
                r_head_len <= commit_len;
            end else begin
                r_head_len <= r_len[w_rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            r_len[r_wr_slot] <= commit_len;
        end
    end

    assign wr_slot   = r_wr_slot;
    assign full      = (r_slot_cnt == CW'(SLOT_NUM));
    assign rx_avail  = r_avail;
    assign head_base = {r_rd_slot, {BW{1'b0}}};
    assign head_len  = r_head_len;
    assign slot_cnt  = r_slot_cnt;

endmodule : rx_slot_ring
`default_nettype wire

// File: rtl/rx_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_slot_ctrl
//  Description : Receive frame FSM and registered memory write path feeding a
//                ring of fixed-size RX frame slots. Optional macro
//                RX_SLOT_DROP_CNT_EN enables the saturating dropped-frame count.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_slot_ctrl
    import vthernet_pkg::*;
#(
    parameter  int SLOT_NUM   = DEF_SLOT_NUM,
    parameter  int SLOT_BYTES = DEF_SLOT_BYTES,
    localparam int SW         = $clog2(SLOT_NUM),
    localparam int BW         = $clog2(SLOT_BYTES),
    localparam int LW         = BW + 1,
    localparam int AW         = SW + BW
)(
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          rx_start_i,
    input  logic          rx_data_v_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_end_i,
    input  logic          rx_abort_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic          host_release_i,
    output logic          rx_avail_o,
    output logic [AW-1:0] head_base_o,
    output logic [BW:0]   head_len_o,
    output logic [SW:0]   slot_cnt_o,
    output logic [15:0]   drop_cnt_o
);

    localparam logic [BW:0] FULL_CNT = LW'(SLOT_BYTES);

    rx_state_t     r_state;
    logic [BW:0]   r_byte_cnt;
    logic [SW-1:0] w_wr_slot;
    logic          w_full;
    logic          w_data_in;
    logic          w_overflow;
    logic          w_wr_en;
    logic          w_commit;
    logic [BW:0]   w_final_len;

    assign w_data_in   = (r_state == RECV) && rx_data_v_i;
    assign w_overflow  = w_data_in && (r_byte_cnt == FULL_CNT);
    assign w_wr_en     = w_data_in && !w_overflow;
    assign w_final_len = r_byte_cnt + {{BW{1'b0}}, w_wr_en};
    assign w_commit    = (r_state == RECV) && rx_end_i && !rx_abort_i &&
                         !w_overflow && (w_final_len != '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= w_wr_en;
            if (w_wr_en) begin
                mem_waddr_o <= {w_wr_slot, r_byte_cnt[BW-1:0]};
                mem_wdata_o <= rx_data_i;
            end
            case (r_state)
                IDLE: begin
                    if (rx_start_i) begin
                        r_byte_cnt <= '0;
                        r_state    <= w_full ? DROP : RECV;
                    end
                end
                RECV: begin
                    r_byte_cnt <= w_final_len;
                    if (rx_abort_i) begin
                        r_state <= IDLE;
                    end else if (w_overflow) begin
                        // An end arriving with the overflow byte closes the frame now.
                        r_state <= rx_end_i ? IDLE : DROP;
                    end else if (rx_end_i) begin
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (rx_end_i || rx_abort_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rx_slot_ring #(
        .SLOT_NUM   (SLOT_NUM),
        .SLOT_BYTES (SLOT_BYTES)
    ) u_ring (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .commit      (w_commit),
        .commit_len  (w_final_len),
        .release_req (host_release_i),
        .wr_slot     (w_wr_slot),
        .full        (w_full),
        .rx_avail    (rx_avail_o),
        .head_base   (head_base_o),
        .head_len    (head_len_o),
        .slot_cnt    (slot_cnt_o)
    );

`ifdef RX_SLOT_DROP_CNT_EN
    logic        w_drop_evt;
    logic [15:0] r_drop_cnt;

    assign w_drop_evt = ((r_state == IDLE) && rx_start_i && w_full) ||
                        (w_overflow && !rx_abort_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 16'h0000;
`endif

endmodule : rx_slot_ctrl
`default_nettype wire

// File: tb/tb_rx_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_slot_ctrl
//  Description : Directed self-checking bench for rx_slot_ctrl (default geometry).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_slot_ctrl;

`ifdef RX_SLOT_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        rx_start_i = 1'b0;
    logic        rx_data_v_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_end_i = 1'b0;
    logic        rx_abort_i = 1'b0;
    logic        host_release_i = 1'b0;
    logic        mem_we_o;
    logic [12:0] mem_waddr_o;
    logic [7:0]  mem_wdata_o;
    logic        rx_avail_o;
    logic [12:0] head_base_o;
    logic [11:0] head_len_o;
    logic [2:0]  slot_cnt_o;
    logic [15:0] drop_cnt_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_wr     = 0;
    int          wr_mark;
    logic [20:0] exp_q[$];
    logic [20:0] mon_e;

    rx_slot_ctrl dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .rx_start_i     (rx_start_i),
        .rx_data_v_i    (rx_data_v_i),
        .rx_data_i      (rx_data_i),
        .rx_end_i       (rx_end_i),
        .rx_abort_i     (rx_abort_i),
        .mem_we_o       (mem_we_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_wdata_o    (mem_wdata_o),
        .host_release_i (host_release_i),
        .rx_avail_o     (rx_avail_o),
        .head_base_o    (head_base_o),
        .head_len_o     (head_len_o),
        .slot_cnt_o     (slot_cnt_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write must match the oldest expected byte, in order.
    always @(negedge wb_clk_i) begin
        if (mem_we_o) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {31'd0, mem_we_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("waddr", {19'd0, mem_waddr_o}, {19'd0, mon_e[20:8]});
                chk("wdata", {24'd0, mem_wdata_o}, {24'd0, mon_e[7:0]});
            end
        end
    end

    task automatic status(input string tag, input int avail, input int cnt,
                          input int base, input int len, input int drop);
        chk({tag, ".avail"}, {31'd0, rx_avail_o}, avail);
        chk({tag, ".cnt"},   {29'd0, slot_cnt_o}, cnt);
        chk({tag, ".base"},  {19'd0, head_base_o}, base);
        chk({tag, ".len"},   {20'd0, head_len_o}, len);
        chk({tag, ".drop"},  {16'd0, drop_cnt_o}, drop);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic host_release();
        host_release_i = 1'b1;
        @(negedge wb_clk_i);
        host_release_i = 1'b0;
    endtask

    // term: 0 end on last byte, 1 end after, 2 abort after, 3 abort+end after.
    // slot < 0 means no byte of this frame is expected in memory.
    task automatic frame(input int n, input int slot, input logic [7:0] seed,
                         input int term, input bit rel_last);
        @(negedge wb_clk_i);
        rx_start_i = 1'b1;
        @(negedge wb_clk_i);
        rx_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_v_i = 1'b1;
            rx_data_i   = 8'(seed + 8'(i));
            if (slot >= 0 && i < 2048) exp_q.push_back({13'(slot * 2048 + i), rx_data_i});
            if (term == 0 && i == n - 1) begin
                rx_end_i       = 1'b1;
                host_release_i = rel_last;
            end
            @(negedge wb_clk_i);
        end
        rx_data_v_i    = 1'b0;
        rx_end_i       = 1'b0;
        host_release_i = 1'b0;
        if (term != 0) begin
            rx_end_i   = (term == 1 || term == 3);
            rx_abort_i = (term >= 2);
            @(negedge wb_clk_i);
            rx_end_i   = 1'b0;
            rx_abort_i = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        chk("rst.we",    {31'd0, mem_we_o}, 32'd0);
        chk("rst.waddr", {19'd0, mem_waddr_o}, 32'd0);
        chk("rst.wdata", {24'd0, mem_wdata_o}, 32'd0);
        status("rst", 0, 0, 0, 0, 0);

        // Three-byte frame ending on its last byte.
        frame(3, 0, 8'hA1, 0, 1'b0);
        status("f3", 1, 1, 0, 3, 0);

        // Fill all four slots, then a fifth frame is dropped.
        do_reset();
        frame(10, 0, 8'h10, 0, 1'b0);
        frame(10, 1, 8'h20, 0, 1'b0);
        frame(10, 2, 8'h30, 0, 1'b0);
        frame(10, 3, 8'h40, 0, 1'b0);
        status("full", 1, 4, 0, 10, 0);
        frame(5, -1, 8'h50, 1, 1'b0);
        status("drop_full", 1, 4, 0, 10, DROP_EN);
        host_release();
        status("rel_full", 1, 3, 2048, 10, DROP_EN);

        // Oversized frame: only SLOT_BYTES written, no commit; next frame reuses slot 0.
        do_reset();
        wr_mark = n_wr;
        frame(2049, 0, 8'h00, 1, 1'b0);
        chk("ovf.writes", n_wr - wr_mark, 2048);
        status("ovf", 0, 0, 0, 0, DROP_EN);
        frame(5, 0, 8'h60, 0, 1'b0);
        status("after_ovf", 1, 1, 0, 5, DROP_EN);

        // Aborted frame leaves counts alone; next frame restarts at offset 0 of slot 1.
        frame(7, 1, 8'h70, 2, 1'b0);
        status("abort", 1, 1, 0, 5, DROP_EN);
        frame(4, 1, 8'h80, 0, 1'b0);
        status("after_abort", 1, 2, 0, 5, DROP_EN);

        // Commit and release in the same cycle.
        frame(3, 2, 8'h90, 0, 1'b1);
        status("cr_same", 1, 2, 2048, 4, DROP_EN);
        host_release();
        status("rel1", 1, 1, 4096, 3, DROP_EN);
        host_release();
        status("rel_empty", 0, 0, 6144, 0, DROP_EN);
        host_release();
        status("rel_ignored", 0, 0, 6144, 0, DROP_EN);

        // Zero-length end and abort-over-end priority both discard.
        frame(0, 3, 8'h00, 1, 1'b0);
        status("zero_len", 0, 0, 6144, 0, DROP_EN);
        frame(2, 3, 8'hB0, 3, 1'b0);
        status("abort_prio", 0, 0, 6144, 0, DROP_EN);

        // Reset mid-frame with two committed slots.
        frame(6, 3, 8'hC0, 0, 1'b0);
        frame(6, 0, 8'hD0, 0, 1'b0);
        status("two", 1, 2, 6144, 6, DROP_EN);
        @(negedge wb_clk_i);
        rx_start_i = 1'b1;
        @(negedge wb_clk_i);
        rx_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data_v_i = 1'b1;
            rx_data_i   = 8'(8'hF0 + 8'(i));
            exp_q.push_back({13'(2048 + i), rx_data_i});
            @(negedge wb_clk_i);
        end
        rx_data_v_i = 1'b0;
        wb_rst_i    = 1'b1;
        @(negedge wb_clk_i);
        chk("mid_rst.we",    {31'd0, mem_we_o}, 32'd0);
        chk("mid_rst.waddr", {19'd0, mem_waddr_o}, 32'd0);
        chk("mid_rst.wdata", {24'd0, mem_wdata_o}, 32'd0);
        status("mid_rst", 0, 0, 0, 0, 0);
        wb_rst_i = 1'b0;
        frame(1, 0, 8'hE0, 0, 1'b0);
        status("post_rst", 1, 1, 0, 1, 0);

        @(negedge wb_clk_i);
        chk("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rx_slot_ctrl
`default_nettype wire
